cache_axi_bridge: RTL and testbench

- Parametrised successor to the two-read-port cache/AXI glue between the L1 caches and the AXI master port in mycpu_top.
- Accepts line-fill requests from NRD read clients (icache, dcache, future uncached/PTW ports) and arbitrates them round-robin onto one AXI4 read channel.
- Accepts dirty-line writebacks from one write client.
- Read and write engines run independently with full-line bursts, so a fill and a writeback can be in flight at the same time.

---
 rtl/cache_axi_bridge.sv | 238 +++++++++++++++++++++++
 tb/tb_cache_axi_bridge.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_bridge.sv
// Round-robin line-fill arbiter for NRD read clients plus a single writeback engine, both on one AXI4 master.
// Optional macro CACHE_AXI_RAW_CHECK_EN holds back fills that hit a line with an in-flight writeback.
module cache_axi_bridge #(
    parameter int NRD        = 2,
    parameter int LINE_BEATS = 4,
    parameter int LINE_W     = 32 * LINE_BEATS
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [NRD-1:0]      rd_req,
    input  logic [32*NRD-1:0]   rd_addr,
    output logic [NRD-1:0]      rd_valid,
    output logic [LINE_W-1:0]   rd_data,
    output logic                rd_err,
    input  logic                wr_req,
    input  logic [31:0]         wr_addr,
    input  logic [LINE_W-1:0]   wr_data,
    output logic                wr_done,
    output logic [3:0]          arid,
    output logic [31:0]         araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [1:0]          arlock,
    output logic [3:0]          arcache,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,
    input  logic [3:0]          rid,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    output logic [3:0]          awid,
    output logic [31:0]         awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [1:0]          awlock,
    output logic [3:0]          awcache,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,
    output logic [3:0]          wid,
    output logic [31:0]         wdata,
    output logic [3:0]          wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [3:0]          bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    localparam int IDX_W  = (NRD > 1) ? $clog2(NRD) : 1;
    localparam int OFF_W  = $clog2(4 * LINE_BEATS);
    localparam int BEAT_W = $clog2(LINE_BEATS);
    localparam int CNT_W  = BEAT_W + 1;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_DONE} rd_state_t;
    typedef enum logic [2:0] {W_IDLE, W_AW, W_DATA, W_RESP, W_DONE} wr_state_t;

    rd_state_t          r_state, r_nxt;
    wr_state_t          w_state, w_nxt;
    logic [IDX_W-1:0]   grant_q, rr_ptr, grant_idx, cand;
    logic               grant_found, blocked;
    logic [31:0]        grant_addr, rd_addr_q, wr_addr_q;
    logic [31:0]        req_addr [NRD];
    logic [LINE_W-1:0]  rd_line, wr_line;
    logic [CNT_W-1:0]   rd_cnt;
    logic [BEAT_W-1:0]  wr_cnt;
    logic               rd_sticky;
    logic               unused_bits;

    function automatic logic [31:0] line_align(input logic [31:0] a);
        return {a[31:OFF_W], {OFF_W{1'b0}}};
    endfunction

    for (genvar g = 0; g < NRD; g++) begin : g_addr
        assign req_addr[g] = rd_addr[32*g +: 32];
    end

    assign unused_bits = ^{rid, bid, bresp};

    assign arid    = 4'(grant_q);
    assign araddr  = rd_addr_q;
    assign arlen   = 8'(LINE_BEATS - 1);
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign rd_data = rd_line;

    assign awid    = 4'd0;
    assign awaddr  = wr_addr_q;
    assign awlen   = 8'(LINE_BEATS - 1);
    assign awsize  = 3'b010;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign wid     = 4'd0;
    assign wstrb   = 4'hF;
    assign wdata   = wr_line[{wr_cnt, 5'b0} +: 32];

    // Scan clients starting just after the last grant so every requester is reached within NRD fills.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_addr  = '0;
        cand        = '0;
        blocked     = 1'b0;
        for (int k = 1; k <= NRD; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NRD);
`ifdef CACHE_AXI_RAW_CHECK_EN
            blocked = (line_align(req_addr[cand]) == wr_addr_q) && (w_state != W_IDLE);
`else
            blocked = 1'b0;
`endif
            if (!grant_found && rd_req[cand] && !blocked) begin
                grant_found = 1'b1;
                grant_idx   = cand;
                grant_addr  = line_align(req_addr[cand]);
            end
        end
    end

    always_comb begin
        r_nxt    = r_state;
        arvalid  = 1'b0;
        rready   = 1'b0;
        rd_valid = '0;
        rd_err   = 1'b0;
        case (r_state)
            R_IDLE: if (grant_found) r_nxt = R_AR;
            R_AR: begin
                arvalid = 1'b1;
                if (arready) r_nxt = R_DATA;
            end
            R_DATA: begin
                rready = 1'b1;
                if (rvalid && rlast) r_nxt = R_DONE;
            end
            R_DONE: begin
                rd_valid = NRD'(1) << grant_q;
                rd_err   = rd_sticky;
                r_nxt    = R_IDLE;
            end
            default: r_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= R_IDLE;
            grant_q   <= '0;
            rr_ptr    <= IDX_W'(NRD - 1);
            rd_addr_q <= '0;
            rd_line   <= '0;
            rd_cnt    <= '0;
            rd_sticky <= 1'b0;
        end else begin
            r_state <= r_nxt;
            case (r_state)
                R_IDLE: if (grant_found) begin
                    grant_q   <= grant_idx;
                    rr_ptr    <= grant_idx;
                    rd_addr_q <= grant_addr;
                end
                R_DATA: if (rvalid) begin
                    // Excess beats from a misbehaving slave are discarded once the line is full.
                    if (rd_cnt < CNT_W'(LINE_BEATS)) begin
                        rd_line[{rd_cnt[BEAT_W-1:0], 5'b0} +: 32] <= rdata;
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                    if (rresp != 2'b00) rd_sticky <= 1'b1;
                end
                R_DONE: begin
                    rd_cnt    <= '0;
                    rd_sticky <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_nxt   = w_state;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wlast   = 1'b0;
        bready  = 1'b0;
        wr_done = 1'b0;
        case (w_state)
            W_IDLE: if (wr_req) w_nxt = W_AW;
            W_AW: begin
                awvalid = 1'b1;
                if (awready) w_nxt = W_DATA;
            end
            W_DATA: begin
                wvalid = 1'b1;
                wlast  = (wr_cnt == BEAT_W'(LINE_BEATS - 1));
                if (wready && wlast) w_nxt = W_RESP;
            end
            W_RESP: begin
                bready = 1'b1;
                if (bvalid) w_nxt = W_DONE;
            end
            W_DONE: begin
                wr_done = 1'b1;
                w_nxt   = W_IDLE;
            end
            default: w_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state   <= W_IDLE;
            wr_addr_q <= '0;
            wr_line   <= '0;
            wr_cnt    <= '0;
        end else begin
            w_state <= w_nxt;
            if (w_state == W_IDLE && wr_req) begin
                wr_addr_q <= line_align(wr_addr);
                wr_line   <= wr_data;
            end
            if (w_state == W_DATA && wready) begin
                wr_cnt <= (wr_cnt == BEAT_W'(LINE_BEATS - 1)) ? '0 : wr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed self-checking bench for cache_axi_bridge; the AXI slave is driven by hand inside each scenario task.
module tb_cache_axi_bridge;

    localparam int NRD        = 2;
    localparam int LINE_BEATS = 4;
    localparam int LINE_W     = 32 * LINE_BEATS;

    logic                aclk = 1'b0;
    logic                aresetn = 1'b0;
    logic [NRD-1:0]      rd_req = '0;
    logic [32*NRD-1:0]   rd_addr = '0;
    logic [NRD-1:0]      rd_valid;
    logic [LINE_W-1:0]   rd_data;
    logic                rd_err;
    logic                wr_req = 1'b0;
    logic [31:0]         wr_addr = '0;
    logic [LINE_W-1:0]   wr_data = '0;
    logic                wr_done;
    logic [3:0]          arid, awid, wid, arcache, awcache, wstrb;
    logic [31:0]         araddr, awaddr, wdata;
    logic [7:0]          arlen, awlen;
    logic [2:0]          arsize, arprot, awsize, awprot;
    logic [1:0]          arburst, arlock, awburst, awlock;
    logic                arvalid, rready, awvalid, wlast, wvalid, bready;
    logic                arready = 1'b0, rlast = 1'b0, rvalid = 1'b0;
    logic                awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [3:0]          rid = '0, bid = '0;
    logic [31:0]         rdata = '0;
    logic [1:0]          rresp = '0, bresp = '0;

    int tests = 0;
    int fails = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;

    cache_axi_bridge #(.NRD(NRD), .LINE_BEATS(LINE_BEATS)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    // Completion pulses are tallied independently so pulse width and multiplicity can be checked.
    always @(posedge aclk) begin
        if (rd_valid != '0) rd_pulses <= rd_pulses + 1;
        if (wr_done) wr_pulses <= wr_pulses + 1;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        rd_req = '0; wr_req = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; rresp = '0;
        repeat (2) tick();
        aresetn = 1'b1;
        tick();
    endtask

    task automatic wait_ar(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (arvalid) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_aw(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (awvalid) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    // Accepts the pending AR after ar_delay cycles and returns one full line starting at d0.
    task automatic serve_read(input logic [31:0] d0, input int ar_delay, input int err_beat);
        repeat (ar_delay) tick();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int b = 0; b < LINE_BEATS; b++) begin
            rvalid = 1'b1;
            rdata  = d0 + 32'(b);
            rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            rlast  = (b == LINE_BEATS - 1);
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        #2;
        tests++;
        if ({arvalid, rready, awvalid, wvalid, wlast, bready, wr_done, rd_err} !== 8'b0) begin
            fails++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000000",
                     {arvalid, rready, awvalid, wvalid, wlast, bready, wr_done, rd_err});
        end
        tests++;
        if (rd_valid !== 2'b00) begin fails++; $display("[TB] FAIL reset_rd_valid: got %b expected 00", rd_valid); end
        do_reset();
    endtask

    task automatic test_single_fill();
        bit ok;
        rd_addr[31:0] = 32'h1C00_0014;
        rd_req = 2'b01;
        wait_ar(ok);
        tests++;
        if (!ok) begin fails++; $display("[TB] FAIL fill_ar_timeout: got arvalid=0 expected 1"); return; end
        tests++;
        if (araddr !== 32'h1C00_0010) begin fails++; $display("[TB] FAIL fill_araddr: got %h expected 1c000010", araddr); end
        tests++;
        if ({arid, arlen, arsize, arburst} !== {4'd0, 8'd3, 3'b010, 2'b01}) begin
            fails++; $display("[TB] FAIL fill_ar_fields: got id=%0d len=%0d size=%0d burst=%0d expected 0/3/2/1", arid, arlen, arsize, arburst);
        end
        tick(); tick();
        tests++;
        if (!arvalid || araddr !== 32'h1C00_0010) begin
            fails++; $display("[TB] FAIL fill_ar_hold: got valid=%b addr=%h expected 1/1c000010", arvalid, araddr);
        end
        serve_read(32'hA0, 0, -1);
        tests++;
        if (rd_valid !== 2'b01) begin fails++; $display("[TB] FAIL fill_rd_valid: got %b expected 01", rd_valid); end
        tests++;
        if (rd_data !== 128'h000000A3_000000A2_000000A1_000000A0) begin
            fails++; $display("[TB] FAIL fill_rd_data: got %h expected 000000a3000000a2000000a1000000a0", rd_data);
        end
        tests++;
        if (rd_err !== 1'b0) begin fails++; $display("[TB] FAIL fill_rd_err: got %b expected 0", rd_err); end
        rd_req = 2'b00;
        tick();
        tests++;
        if (rd_valid !== 2'b00 || rd_data[31:0] !== 32'hA0) begin
            fails++; $display("[TB] FAIL fill_pulse_width: got valid=%b data0=%h expected 00/a0", rd_valid, rd_data[31:0]);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [3:0] exp_id;
        do_reset();
        rd_addr = {32'h0000_2004, 32'h0000_0108};
        rd_req  = 2'b11;
        for (int n = 0; n < 4; n++) begin
            exp_id = 4'(n % 2);
            wait_ar(ok);
            tests++;
            if (!ok) begin fails++; $display("[TB] FAIL rr_ar_timeout: burst %0d got arvalid=0 expected 1", n); break; end
            tests++;
            if (arid !== exp_id || araddr !== ((n % 2 == 0) ? 32'h0000_0100 : 32'h0000_2000)) begin
                fails++; $display("[TB] FAIL rr_grant: burst %0d got id=%0d addr=%h expected id=%0d", n, arid, araddr, exp_id);
            end
            serve_read(32'h100 * 32'(n), 1, -1);
            tests++;
            if (rd_valid !== (2'b01 << exp_id)) begin
                fails++; $display("[TB] FAIL rr_rd_valid: burst %0d got %b expected %b", n, rd_valid, 2'b01 << exp_id);
            end
        end
        rd_req = 2'b00;
        tick(); tick();
    endtask

    task automatic test_read_error();
        bit ok;
        rd_addr[31:0] = 32'h0000_0040;
        rd_req = 2'b01;
        wait_ar(ok);
        tests++;
        if (!ok) begin fails++; $display("[TB] FAIL err_ar_timeout: got arvalid=0 expected 1"); return; end
        serve_read(32'hE0, 0, 2);
        tests++;
        if ({rd_valid, rd_err} !== 3'b011) begin fails++; $display("[TB] FAIL err_flag: got valid=%b err=%b expected 01/1", rd_valid, rd_err); end
        wait_ar(ok);
        serve_read(32'hF0, 0, -1);
        tests++;
        if ({rd_valid, rd_err} !== 3'b010) begin fails++; $display("[TB] FAIL err_cleared: got valid=%b err=%b expected 01/0", rd_valid, rd_err); end
        rd_req = 2'b00;
        tick(); tick();
    endtask

    task automatic test_writeback();
        bit ok;
        int beat = 0;
        bit tog = 1'b1;
        int w0 = wr_pulses;
        wr_data = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
        wr_addr = 32'h0000_1238;
        wr_req  = 1'b1;
        wait_aw(ok);
        tests++;
        if (!ok) begin fails++; $display("[TB] FAIL wb_aw_timeout: got awvalid=0 expected 1"); wr_req = 1'b0; return; end
        tests++;
        if ({awaddr, awlen, awsize, awburst, awid} !== {32'h0000_1230, 8'd3, 3'b010, 2'b01, 4'd0}) begin
            fails++; $display("[TB] FAIL wb_aw_fields: got addr=%h len=%0d size=%0d burst=%0d expected 00001230/3/2/1", awaddr, awlen, awsize, awburst);
        end
        tests++;
        if (wvalid !== 1'b0) begin fails++; $display("[TB] FAIL wb_w_early: got wvalid=%b expected 0", wvalid); end
        awready = 1'b1;
        tick();
        awready = 1'b0;
        for (int g = 0; g < 20 && beat < LINE_BEATS; g++) begin
            wready = tog;
            tests++;
            if (!wvalid || wdata !== (32'hD000_0000 + 32'(beat)) || wlast !== (beat == LINE_BEATS - 1) || wstrb !== 4'hF) begin
                fails++; $display("[TB] FAIL wb_beat: beat %0d got valid=%b data=%h last=%b expected 1/%h/%b",
                                  beat, wvalid, wdata, wlast, 32'hD000_0000 + 32'(beat), beat == LINE_BEATS - 1);
            end
            tick();
            if (tog) beat++;
            tog = ~tog;
        end
        wready = 1'b0;
        tests++;
        if ({bready, wvalid} !== 2'b10) begin fails++; $display("[TB] FAIL wb_resp: got bready=%b wvalid=%b expected 1/0", bready, wvalid); end
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        wr_req = 1'b0;
        tests++;
        if (wr_done !== 1'b1) begin fails++; $display("[TB] FAIL wb_done: got %b expected 1", wr_done); end
        tick(); tick();
        tests++;
        if (wr_pulses - w0 != 1) begin fails++; $display("[TB] FAIL wb_done_count: got %0d expected 1", wr_pulses - w0); end
    endtask

    task automatic test_concurrent();
        int r0, w0;
        do_reset();
        r0 = rd_pulses; w0 = wr_pulses;
        rd_addr[31:0] = 32'h0000_0300;
        wr_addr = 32'h0000_0500;
        wr_data = {32'h4, 32'h3, 32'h2, 32'h1};
        rd_req = 2'b01;
        wr_req = 1'b1;
        tick();
        tests++;
        if ({arvalid, awvalid} !== 2'b11) begin fails++; $display("[TB] FAIL conc_addr_phase: got ar=%b aw=%b expected 1/1", arvalid, awvalid); end
        arready = 1'b1; awready = 1'b1;
        tick();
        arready = 1'b0; awready = 1'b0;
        for (int b = 0; b < LINE_BEATS; b++) begin
            rvalid = 1'b1; rdata = 32'hC0 + 32'(b); rlast = (b == LINE_BEATS - 1); wready = 1'b1;
            tests++;
            if (wdata !== 32'(b + 1)) begin fails++; $display("[TB] FAIL conc_wdata: beat %0d got %h expected %h", b, wdata, b + 1); end
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0; wready = 1'b0;
        rd_req = 2'b00;
        tests++;
        if (rd_valid !== 2'b01 || rd_data !== 128'h000000C3_000000C2_000000C1_000000C0) begin
            fails++; $display("[TB] FAIL conc_read: got valid=%b data=%h expected 01/000000c3000000c2000000c1000000c0", rd_valid, rd_data);
        end
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        wr_req = 1'b0;
        repeat (3) tick();
        tests++;
        if (rd_pulses - r0 != 1 || wr_pulses - w0 != 1) begin
            fails++; $display("[TB] FAIL conc_pulses: got rd=%0d wr=%0d expected 1/1", rd_pulses - r0, wr_pulses - w0);
        end
    endtask

    task automatic test_raw_check();
        bit ok;
        do_reset();
        wr_addr = 32'h0000_0080;
        wr_req  = 1'b1;
        wait_aw(ok);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        wready = 1'b1;
        for (int i = 0; i < 20 && !bready; i++) tick();
        wready = 1'b0;
        tests++;
        if (bready !== 1'b1) begin fails++; $display("[TB] FAIL raw_wresp_timeout: got bready=%b expected 1", bready); end
        rd_addr = {32'h0000_0200, 32'h0000_0084};
        rd_req  = 2'b11;
        wait_ar(ok);
`ifdef CACHE_AXI_RAW_CHECK_EN
        tests++;
        if (!ok || arid !== 4'd1 || araddr !== 32'h0000_0200) begin
            fails++; $display("[TB] FAIL raw_skip: got ok=%b id=%0d addr=%h expected 1/1/00000200", ok, arid, araddr);
        end
        serve_read(32'h50, 0, -1);
        rd_req = 2'b01;
        repeat (4) tick();
        tests++;
        if (arvalid !== 1'b0) begin fails++; $display("[TB] FAIL raw_hold: got arvalid=%b expected 0", arvalid); end
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        wr_req = 1'b0;
        wait_ar(ok);
        tests++;
        if (!ok || arid !== 4'd0 || araddr !== 32'h0000_0080) begin
            fails++; $display("[TB] FAIL raw_release: got ok=%b id=%0d addr=%h expected 1/0/00000080", ok, arid, araddr);
        end
        serve_read(32'h60, 0, -1);
`else
        tests++;
        if (!ok || arid !== 4'd0 || araddr !== 32'h0000_0080) begin
            fails++; $display("[TB] FAIL raw_nocheck: got ok=%b id=%0d addr=%h expected 1/0/00000080", ok, arid, araddr);
        end
        serve_read(32'h60, 0, -1);
        rd_req = 2'b10;
        wait_ar(ok);
        tests++;
        if (!ok || arid !== 4'd1) begin fails++; $display("[TB] FAIL raw_nocheck_next: got ok=%b id=%0d expected 1/1", ok, arid); end
        serve_read(32'h50, 0, -1);
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        wr_req = 1'b0;
`endif
        rd_req = 2'b00;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        int r0 = rd_pulses;
        rd_addr[63:32] = 32'h0000_0400;
        rd_req = 2'b10;
        wait_ar(ok);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h77;
        tick();
        rdata = 32'h78;
        #2 aresetn = 1'b0;
        #1;
        tests++;
        if ({rd_valid, arvalid, rready, awvalid, wvalid, wlast, bready, wr_done, rd_err} !== 10'b0) begin
            fails++; $display("[TB] FAIL midreset_outputs: got %b expected 0000000000",
                              {rd_valid, arvalid, rready, awvalid, wvalid, wlast, bready, wr_done, rd_err});
        end
        rvalid = 1'b0;
        rd_req = 2'b00;
        repeat (3) tick();
        aresetn = 1'b1;
        repeat (3) tick();
        tests++;
        if (rd_pulses != r0 || arvalid !== 1'b0) begin
            fails++; $display("[TB] FAIL midreset_no_pulse: got pulses=%0d arvalid=%b expected 0/0", rd_pulses - r0, arvalid);
        end
    endtask

    initial begin
        test_reset();
        test_single_fill();
        test_round_robin();
        test_read_error();
        test_writeback();
        test_concurrent();
        test_raw_check();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
